// File: rtl/program_counter_unit_pkg.sv
// -----------------------------------------------------------------------------
// program_counter_unit_pkg
//   Shared CPU control definitions used by the program counter unit:
//   - pcu_state_t and its state constants (BOOT, RUN, REDIRECT, HALTED)
//   - default sequential step and reset vector
//   - WORD_ALIGN mask plus a helper that clears the byte-offset bits
// -----------------------------------------------------------------------------
package program_counter_unit_pkg;

  // State encoding kept as plain constants so older code that compares
  // against raw 2-bit values keeps working.
  typedef logic [1:0] pcu_state_t;

  localparam pcu_state_t PCU_BOOT     = 2'd0;
  localparam pcu_state_t PCU_RUN      = 2'd1;
  localparam pcu_state_t PCU_REDIRECT = 2'd2;
  localparam pcu_state_t PCU_HALTED   = 2'd3;

  localparam int unsigned PCU_PC_STEP_DEFAULT      = 4;
  localparam logic [31:0] PCU_RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Clears bits [1:0]: fetch addresses are always word aligned.
  localparam logic [31:0] WORD_ALIGN = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN;
  endfunction

endpackage

// File: rtl/program_counter_unit.sv
// -----------------------------------------------------------------------------
// program_counter_unit
//   Generates instruction fetch addresses. After reset the unit spends one
//   cycle in BOOT, then offers sequential addresses (valid/ready handshake).
//   A branch redirects to a word-aligned target with a one-cycle bubble, and
//   halt parks the unit without losing the current address.
//
// Ports
//   clk               in   clock, all state updates on its rising edge
//   rst_n             in   asynchronous active-low reset
//   halt              in   level; suppresses new fetch addresses while high
//   branch_valid      in   single-cycle redirect request
//   branch_target     in   [31:0] redirect address
//   fetch_ready       in   fetcher accepts program_counter this cycle
//   program_counter   out  [31:0] address offered to the fetcher
//   pc_valid          out  program_counter is a valid fetch address
//   branch_misaligned out  one-cycle pulse, accepted target had [1:0] != 0
// -----------------------------------------------------------------------------
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PCU_RESET_VECTOR_DEFAULT,
  parameter int unsigned PC_STEP      = PCU_PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        fetch_ready,
  output logic [31:0] program_counter,
  output logic        pc_valid,
  output logic        branch_misaligned
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  pcu_state_t  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        misaligned_reg, misaligned_next;
  logic        accept;

  // Only RUN presents a valid address, so the handshake is RUN && ready.
  assign accept = (state_reg == PCU_RUN) && fetch_ready;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    misaligned_next = 1'b0;

    case (state_reg)
      PCU_BOOT: begin
        // Branches are ignored here; the PC still holds the reset vector.
        state_next = halt ? PCU_HALTED : PCU_RUN;
      end

      PCU_RUN: begin
        if (branch_valid) begin
          // Redirect wins over any increment, accepted or pending.
          pc_next         = word_align(branch_target);
          misaligned_next = |branch_target[1:0];
          state_next      = PCU_REDIRECT;
        end else begin
          // An address accepted in the same cycle halt rises still advances.
          if (accept) begin
            pc_next = pc_reg + STEP;
          end
          if (halt) begin
            state_next = PCU_HALTED;
          end
        end
      end

      PCU_REDIRECT: begin
        if (branch_valid) begin
          // Back-to-back redirect: take the newer target, one more bubble.
          pc_next         = word_align(branch_target);
          misaligned_next = |branch_target[1:0];
          state_next      = PCU_REDIRECT;
        end else begin
          state_next = halt ? PCU_HALTED : PCU_RUN;
        end
      end

      PCU_HALTED: begin
        if (branch_valid) begin
          pc_next         = word_align(branch_target);
          misaligned_next = |branch_target[1:0];
          state_next      = halt ? PCU_HALTED : PCU_REDIRECT;
        end else if (!halt) begin
          state_next = PCU_RUN;
        end
      end

      default: begin
        state_next = PCU_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= PCU_BOOT;
      pc_reg         <= RESET_VECTOR;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      misaligned_reg <= misaligned_next;
    end
  end

  // All outputs come straight from registers (pc_valid is a decode of the
  // state register only), so nothing combinational reaches them from inputs.
  assign program_counter   = pc_reg;
  assign pc_valid          = (state_reg == PCU_RUN);
  assign branch_misaligned = misaligned_reg;

endmodule

// File: tb/tb_program_counter_unit.sv
// -----------------------------------------------------------------------------
// tb_program_counter_unit
//   Table-driven bench for program_counter_unit. Each vector holds the inputs
//   applied before a rising edge and the outputs expected after it. Expected
//   values are queued when stimulus is driven and popped when the outputs are
//   sampled. Hand-written sequences cover reset-related corner cases.
// -----------------------------------------------------------------------------
module tb_program_counter_unit;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        fetch_ready;
  logic [31:0] program_counter;
  logic        pc_valid;
  logic        branch_misaligned;

  program_counter_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .halt              (halt),
    .branch_valid      (branch_valid),
    .branch_target     (branch_target),
    .fetch_ready       (fetch_ready),
    .program_counter   (program_counter),
    .pc_valid          (pc_valid),
    .branch_misaligned (branch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        h;
    logic        bv;
    logic [31:0] bt;
    logic        fr;
    logic [31:0] pc;
    logic        v;
    logic        m;
    string       tag;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        m;
    string       tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  function automatic vec_t mk(input logic h, input logic bv, input logic [31:0] bt,
                              input logic fr, input logic [31:0] pc, input logic v,
                              input logic m, input string tag);
    vec_t r;
    r.h = h; r.bv = bv; r.bt = bt; r.fr = fr;
    r.pc = pc; r.v = v; r.m = m; r.tag = tag;
    return r;
  endfunction

  // Pop the oldest expectation and compare it to the current outputs.
  task automatic check_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    $display("[%0t] %s: pc=%08h valid=%0b mis=%0b (want pc=%08h valid=%0b mis=%0b)",
             $time, e.tag, program_counter, pc_valid, branch_misaligned, e.pc, e.v, e.m);
    n_compared++;
    if (program_counter !== e.pc) begin
      n_mismatched++;
      $display("FAIL %s.pc: got %08h want %08h", e.tag, program_counter, e.pc);
    end
    n_compared++;
    if (pc_valid !== e.v) begin
      n_mismatched++;
      $display("FAIL %s.pc_valid: got %0b want %0b", e.tag, pc_valid, e.v);
    end
    n_compared++;
    if (branch_misaligned !== e.m) begin
      n_mismatched++;
      $display("FAIL %s.branch_misaligned: got %0b want %0b", e.tag, branch_misaligned, e.m);
    end
  endtask

  // Immediate (non-clocked) expectation, e.g. right after async reset.
  task automatic expect_now(input logic [31:0] pc, input logic v, input logic m,
                            input string tag);
    exp_t e;
    e.pc = pc; e.v = v; e.m = m; e.tag = tag;
    sb_q.push_back(e);
    check_outputs();
  endtask

  // Drive inputs on the falling edge, queue the expectation, sample 1 after
  // the next rising edge.
  task automatic step(input vec_t t);
    exp_t e;
    @(negedge clk);
    halt          = t.h;
    branch_valid  = t.bv;
    branch_target = t.bt;
    fetch_ready   = t.fr;
    e.pc = t.pc; e.v = t.v; e.m = t.m; e.tag = t.tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main vector table (RESET_VECTOR=0, PC_STEP=4).
    //             h  bv  target        fr  exp_pc        v  m
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0000, 1, 0, "boot_to_run"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0004, 1, 0, "seq_4"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0008, 1, 0, "seq_8"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_000C, 1, 0, "seq_c"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0010, 1, 0, "seq_10"));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0010, 1, 0, "stall_1"));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0010, 1, 0, "stall_2"));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0010, 1, 0, "stall_3"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0014, 1, 0, "stall_release"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0018, 1, 0, "seq_18"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_001C, 1, 0, "seq_1c"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0020, 1, 0, "seq_20"));
    vecs.push_back(mk(0, 1, 32'h0000_0103, 1, 32'h0000_0100, 0, 1, "branch_mis"));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0100, 1, 0, "after_redirect"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0104, 1, 0, "seq_104"));
    vecs.push_back(mk(0, 1, 32'h0000_003C, 0, 32'h0000_003C, 0, 0, "branch_pending"));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0000_003C, 1, 0, "after_redirect2"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0040, 1, 0, "seq_40"));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0000_0040, 0, 0, "halt_1"));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0000_0040, 0, 0, "halt_2"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0040, 1, 0, "halt_resume"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0044, 1, 0, "seq_44"));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'h0000_0048, 0, 0, "halt_with_accept"));
    vecs.push_back(mk(1, 1, 32'h0000_0200, 0, 32'h0000_0200, 0, 0, "branch_in_halt"));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'h0000_0200, 0, 0, "halt_hold_200"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0200, 1, 0, "halt_drop_200"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0204, 1, 0, "seq_204"));
    vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0000_0204, 0, 0, "halt_again"));
    vecs.push_back(mk(0, 1, 32'h0000_0302, 0, 32'h0000_0300, 0, 1, "halt_branch_go"));
    vecs.push_back(mk(1, 0, 32'h0,         1, 32'h0000_0300, 0, 0, "redirect_to_halt"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0300, 1, 0, "halted_to_run"));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 0, 0, "branch_high"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hFFFF_FFF8, 1, 0, "wrap_ff8"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 0, "wrap_ffc"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0000, 1, 0, "wrap_0"));
    vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0004, 1, 0, "wrap_4"));
    vecs.push_back(mk(0, 1, 32'h0000_0500, 1, 32'h0000_0500, 0, 0, "b2b_branch_1"));
    vecs.push_back(mk(0, 1, 32'h0000_0601, 0, 32'h0000_0600, 0, 1, "b2b_branch_2"));
    vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0000_0600, 1, 0, "b2b_run"));

    rst_n         = 1'b0;
    halt          = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    fetch_ready   = 1'b1;
    #1;
    expect_now(32'h0, 1'b0, 1'b0, "reset_state");

    // Release reset shortly after a rising edge so the next edge is the first.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    expect_now(32'h0, 1'b0, 1'b0, "boot_cycle");

    foreach (vecs[i]) step(vecs[i]);

    // Reset asserted while in REDIRECT with a misaligned pulse pending.
    step(mk(0, 1, 32'h0000_0701, 0, 32'h0000_0700, 0, 1, "redirect_pre_reset"));
    #2 rst_n = 1'b0;
    #1;
    expect_now(32'h0, 1'b0, 1'b0, "reset_mid_redirect");

    // Branch during BOOT is ignored.
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(mk(0, 1, 32'h0000_0800, 1, 32'h0000_0000, 1, 0, "boot_branch_ignored"));
    step(mk(0, 0, 32'h0,         1, 32'h0000_0004, 1, 0, "boot_branch_next"));

    // halt held through reset release: BOOT goes to HALTED.
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(mk(1, 0, 32'h0, 1, 32'h0000_0000, 0, 0, "boot_to_halted"));
    step(mk(1, 0, 32'h0, 1, 32'h0000_0000, 0, 0, "halted_hold"));
    step(mk(0, 0, 32'h0, 1, 32'h0000_0000, 1, 0, "halted_resume"));
    step(mk(0, 0, 32'h0, 1, 32'h0000_0004, 1, 0, "halted_resume_seq"));

    if (sb_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/program_counter_unit.md
PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter PC_STEP, default 4: sequential address increment in bytes.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 halt  input  1  level; while high, no new fetch address is offered.
REQ-006 branch_valid  input  1  single-cycle redirect request.
REQ-007 branch_target  input  32  redirect address, sampled when branch_valid=1.
REQ-008 fetch_ready  input  1  the downstream instruction fetcher accepts the current address.
REQ-009 program_counter  output  32  address offered to the instruction fetcher; registered.
REQ-010 pc_valid  output  1  program_counter is a valid fetch address; registered.
REQ-011 branch_misaligned  output  1  one-cycle pulse: the accepted branch_target had bits [1:0] != 0.

Function
REQ-012 The block SHALL implement four states: BOOT, RUN, REDIRECT, HALTED.
REQ-013 Handshake: an address is accepted in any cycle where pc_valid=1 and fetch_ready=1.
REQ-014 While pc_valid=1 and fetch_ready=0, program_counter SHALL hold stable.
REQ-015 BOOT: pc_valid=0; next state is HALTED if halt=1, otherwise RUN.
REQ-016 RUN: pc_valid=1; on acceptance with no branch, program_counter SHALL advance by PC_STEP in the next cycle.
REQ-017 Increment SHALL be modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000, with no flag and no stall.
REQ-018 Redirect: branch_valid=1 in any state except BOOT SHALL load {branch_target[31:2],2'b00} into program_counter in the next cycle.
REQ-019 A redirect SHALL enter REDIRECT for exactly one cycle with pc_valid=0 (bubble), then go to RUN, or to HALTED if halt=1.
REQ-020 branch_misaligned SHALL pulse high in the cycle after a redirect whose branch_target[1:0] != 0; otherwise it is 0.
REQ-021 Branch plus acceptance in the same cycle: the current address counts as accepted; the redirect wins and no increment occurs.
REQ-022 Branch while pc_valid=1 and fetch_ready=0: the pending address SHALL be discarded and replaced by the target.
REQ-023 halt=1 in RUN SHALL enter HALTED in the next cycle.
REQ-024 If acceptance and halt occur in the same cycle, the increment SHALL still apply.
REQ-025 HALTED: pc_valid=0 and program_counter held; halt=0 returns to RUN in the next cycle.
REQ-026 Branch while HALTED: the target SHALL be loaded, and the state SHALL be REDIRECT if halt=0, otherwise HALTED.
REQ-027 Branch during BOOT SHALL be ignored.
REQ-028 Outputs SHALL have no combinational path from any input.

Reset
REQ-029 rst_n=0 SHALL immediately force the following, regardless of state or any pending handshake:
- program_counter = RESET_VECTOR
- pc_valid = 0
- branch_misaligned = 0
- state = BOOT
REQ-030 After rst_n deasserts, the first rising edge of clk SHALL leave BOOT per REQ-015.
REQ-031 pc_valid SHALL first be 1 in the second cycle after reset release.

Structure
REQ-032 A shared cpu control package SHALL hold:
- the pcu state typedef (BOOT, RUN, REDIRECT, HALTED)
- the PC_STEP default
- the RESET_VECTOR default
- a WORD_ALIGN mask constant
REQ-033 The block SHALL be implemented flat, with no sub-modules: one state register, one PC register, one pulse register.

Verification
REQ-034 Reset release with fetch_ready=1 held: pc_valid=0 in cycle 1; then program_counter = 0x0, 0x4, 0x8 on consecutive cycles with pc_valid=1.
REQ-035 fetch_ready low for 3 cycles at PC=0x10: PC holds 0x10 throughout; after fetch_ready rises, 0x14 follows.
REQ-036 branch_valid with target 0x0000_0103 at PC=0x20:
- next cycle: PC=0x100, pc_valid=0, branch_misaligned=1
- following cycle: PC=0x100, pc_valid=1
REQ-037 Start PC=0xFFFF_FFF8 with fetch_ready=1: sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 halt high 2 cycles at PC=0x40 (not accepted): pc_valid=0 while halted, PC=0x40; resume gives 0x40 valid.
REQ-039 Halt and branch combinations:
- branch to 0x200 during halt: PC=0x200, pc_valid stays 0 until halt drops.
- rst_n asserted mid-redirect: PC=RESET_VECTOR and pc_valid=0 asynchronously.
